seq_div_2nby_n: RTL and testbench

- Iterative restoring divider. It is the inverse companion of the 8x8 approximate multipliers.
- It takes a 2N-bit product and an N-bit operand and recovers the other N-bit operand plus a remainder.
- The error-characterisation harness uses it to back-solve operands from approximate products and to measure the recovered-operand deviation.
- It has a single clock domain, a valid/ready handshake on input and output, and retires one quotient bit per cycle.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/seq_div_2nby_n.sv | 132 +++++++++++++
 tb/tb_seq_div_2nby_n.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential 2N-by-N restoring divider:
// state encoding, default operand width and bit-counter sizing.
package div_pkg;

  localparam int unsigned DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
import div_pkg::*;

module div_step #(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] r,
  input  logic         in_bit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_next,
  output logic         qbit
);

  logic [N:0] t;

  // The compare is N+1 bits wide; once t >= divisor the true difference is
  // below divisor, so the low N bits of the subtraction are exact.
  always_comb begin
    t      = {r, in_bit};
    qbit   = (t >= {1'b0, divisor});
    r_next = qbit ? (t[N-1:0] - divisor) : t[N-1:0];
  end

endmodule

// File: rtl/seq_div_2nby_n.sv
// Iterative 2N-by-N unsigned restoring divider with valid/ready handshakes,
// retiring one quotient bit per cycle; used to back-solve multiplier operands.
import div_pkg::*;

module seq_div_2nby_n #(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  qsh_q, qsh_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  stepR;
  logic          stepQbit;

  div_step #(.N(N)) u_step (
    .r       (r_q),
    .in_bit  (qsh_q[N-1]),
    .divisor (divisor_q),
    .r_next  (stepR),
    .qbit    (stepQbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    qsh_d       = qsh_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          divisor_d = divisor;
          qsh_d     = dividend[N-1:0];
          r_d       = dividend[2*N-1:N];
          cnt_d     = CW'(N - 1);
          // Exceptions resolve immediately; divide-by-zero wins over overflow.
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend[N-1:0];
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (dividend[2*N-1:N] >= divisor) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        qsh_d = {qsh_q[N-2:0], stepQbit};
        r_d   = stepR;
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {qsh_q[N-2:0], stepQbit};
          remainder_d = stepR;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      qsh_q       <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      qsh_q       <= qsh_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div_2nby_n.sv
// Self-checking bench for seq_div_2nby_n: directed vectors, backpressure,
// mid-operation reset and a randomised sweep against an integer-division model.
module tb_seq_div_2nby_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int checkCount     = 0;
  int passCount      = 0;
  int acceptCount    = 0;
  int handshakeCount = 0;

  seq_div_2nby_n #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Count input accepts and output handshakes to prove one result per accept.
  always @(posedge clk) begin
    if (in_valid && in_ready) acceptCount++;
    if (!rst && out_valid && out_ready) handshakeCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (in_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 in_valid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  // Edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic waitResult(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else cycles++;
    end
    if (!seen) checkOutput("resultTimeout", 32'd0, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [7:0] q, input logic [7:0] r,
                             input logic dbz, input logic ovf);
    checkOutput({tag, ".quotient"},  32'(quotient),    32'(q));
    checkOutput({tag, ".remainder"}, 32'(remainder),   32'(r));
    checkOutput({tag, ".flags"},     32'({div_by_zero, overflow}), 32'({dbz, ovf}));
  endtask

  function automatic logic [17:0] goldenDiv(input logic [15:0] dd, input logic [7:0] dv);
    int a, b;
    a = int'(dd);
    b = int'(dv);
    if (b == 0) return {8'hFF, dd[7:0], 2'b10};
    if (int'(dd[15:8]) >= b) return {8'hFF, 8'h00, 2'b01};
    return {8'(a / b), 8'(a % b), 2'b00};
  endfunction

  initial begin
    int          lat;
    int          savedAccept;
    int          stall;
    int          mode;
    bit          stable;
    bit          sweepStable;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [17:0] exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 32'd0);
    checkOutput("resetOutputs", 32'({out_valid, quotient, remainder, div_by_zero, overflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleInReady", 32'(in_ready), 32'd1);

    applyStimulus(16'h2A3F, 8'h5B);
    waitResult(lat);
    checkOutput("t1Latency", 32'(lat), 32'd9);
    checkResult("t1", 8'h76, 8'h4D, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1OneCycle", 32'(out_valid), 32'd0);

    applyStimulus(16'hFE01, 8'hFF);
    waitResult(lat);
    checkOutput("maxQLatency", 32'(lat), 32'd9);
    checkResult("maxQ", 8'hFF, 8'h00, 1'b0, 1'b0);

    applyStimulus(16'h1234, 8'h00);
    waitResult(lat);
    checkOutput("dbzLatency", 32'(lat), 32'd1);
    checkResult("dbz", 8'hFF, 8'h34, 1'b1, 1'b0);

    applyStimulus(16'h6400, 8'h64);
    waitResult(lat);
    checkOutput("ovfLatency", 32'(lat), 32'd1);
    checkResult("ovf", 8'hFF, 8'h00, 1'b0, 1'b1);

    applyStimulus(16'hFF00, 8'h00);
    waitResult(lat);
    checkResult("dbzPriority", 8'hFF, 8'h00, 1'b1, 1'b0);

    // Backpressure: 256/3 = 85 rem 1, held while a competing request waits.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(16'h0100, 8'h03);
    waitResult(lat);
    checkResult("bp", 8'h55, 8'h01, 1'b0, 1'b0);
    in_valid    = 1'b1;
    dividend    = 16'h0010;
    divisor     = 8'h02;
    savedAccept = acceptCount;
    stable      = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || quotient != 8'h55 || remainder != 8'h01 || in_ready) stable = 1'b0;
    end
    checkOutput("bpStable", 32'(stable), 32'd1);
    checkOutput("bpNoAccept", 32'(acceptCount), 32'(savedAccept));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpReturnIdle", 32'({out_valid, in_ready}), 32'b01);
    checkOutput("bpHold", 32'({quotient, remainder}), 32'h5501);

    // Reset in the middle of CALC discards the operation.
    applyStimulus(16'h2A3F, 8'h5B);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstOutputs", 32'({out_valid, quotient, remainder, div_by_zero, overflow}), 32'd0);
    rst    = 1'b0;
    stable = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) stable = 1'b0;
    end
    checkOutput("midRstNoValid", 32'(stable), 32'd1);
    applyStimulus(16'h0051, 8'h09);
    waitResult(lat);
    checkResult("postRst", 8'h09, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // Random sweep with output stalls; mix of legal, overflow and zero divisors.
    sweepStable = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      dv   = 8'($urandom);
      dd   = 16'($urandom);
      mode = int'($urandom_range(0, 7));
      if (mode == 0) dv = 8'h00;
      if (mode >= 3 && dv != 8'h00) dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
      exp = goldenDiv(dd, dv);
      out_ready = 1'b0;
      applyStimulus(dd, dv);
      waitResult(lat);
      checkOutput("sweep", 32'({quotient, remainder, div_by_zero, overflow}), 32'(exp));
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        @(negedge clk);
        if (!out_valid || {quotient, remainder, div_by_zero, overflow} != exp) sweepStable = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) sweepStable = 1'b0;
    end
    checkOutput("sweepStable", 32'(sweepStable), 32'd1);

    // One operation was discarded by the mid-operation reset.
    checkOutput("handshakeCount", 32'(handshakeCount), 32'(acceptCount - 1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
